// File: rtl/fifo_reader.sv
// Non-FWFT FIFO to valid/ready stream adapter with a 2-entry skid buffer,
// burst framing (out_last) and an accepted-word counter.
module fifo_reader #(
    parameter int DWIDTH    = 32,
    parameter int BURST_LEN = 16
) (
    input  logic              read_clock,
    input  logic              read_reset,
    input  logic              fifo_flush,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_read_data,
    output logic              fifo_read_enable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic [15:0]       words_sent
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    localparam logic [15:0] LAST = 16'(BURST_LEN - 1);

    occ_t              occ, occ_next;
    logic              inflight;
    logic [DWIDTH-1:0] head, tail, head_next, tail_next;
    logic [15:0]       burst_count, sent_count;
    logic              pop, push;
    logic [2:0]        level;

    assign out_valid  = (occ != EMPTY);
    assign pop        = out_valid & out_ready;
    assign push       = inflight & ~fifo_flush;
    assign out_data   = head;
    assign out_last   = out_valid & (burst_count == LAST);
    assign words_sent = sent_count;

    // Slots committed after this cycle; a read is only issued if it fits.
    assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_read_enable = ~fifo_empty & ~fifo_flush & ~read_reset
                            & (level < 3'd2);

    always_comb begin
        occ_next  = occ;
        head_next = head;
        tail_next = tail;
        case (occ)
            EMPTY: begin
                if (push) begin
                    occ_next  = ONE;
                    head_next = fifo_read_data;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_next = fifo_read_data;
                end else if (push) begin
                    occ_next  = TWO;
                    tail_next = fifo_read_data;
                end else if (pop) begin
                    occ_next = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    occ_next  = ONE;
                    head_next = tail;
                end
            end
            default: occ_next = EMPTY;
        endcase
        if (fifo_flush) begin
            occ_next = EMPTY;
        end
    end

    always_ff @(posedge read_clock) begin
        if (read_reset) begin
            occ         <= EMPTY;
            inflight    <= 1'b0;
            burst_count <= 16'd0;
            sent_count  <= 16'd0;
        end else begin
            occ      <= occ_next;
            inflight <= fifo_read_enable;
            if (fifo_flush) begin
                burst_count <= 16'd0;
            end else if (pop) begin
                burst_count <= (burst_count == LAST) ? 16'd0
                                                     : burst_count + 16'd1;
            end
            // A pop during flush still left the block, so it is counted.
            if (pop) begin
                sent_count <= sent_count + 16'd1;
            end
        end
    end

    always_ff @(posedge read_clock) begin
        head <= head_next;
        tail <= tail_next;
    end

endmodule
